// File: rtl/pipe_addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_addsub_pkg
//  Description : Shared definitions for the segmented pipelined add/subtract
//                unit: operation encoding and slice-position helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_addsub_pkg;

    // Operation select: subtract is a + ~b + 1, so OP_SUB doubles as carry-in.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SEGS  = 4;

    // Bit position of the least significant bit of slice idx.
    function automatic int unsigned seg_lsb(input int unsigned idx,
                                            input int unsigned seg_width);
        return idx * seg_width;
    endfunction

endpackage : pipe_addsub_pkg
`default_nettype wire

// File: rtl/pipe_addsub_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_addsub_if
//  Description : Operand/result handshake bundle of the pipelined add/sub
//                unit. master = producer/consumer side, slave = the unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_addsub_if #(
    parameter int WIDTH = 32
) ();
    // Input side
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    // Output side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );

endinterface : pipe_addsub_if
`default_nettype wire

// File: rtl/pipe_addsub_add_seg.sv
`default_nettype none
// ============================================================================
//  Module      : add_seg
//  Description : One carry-chain segment: adds slice IDX of the operands plus
//                the incoming carry, merges the slice result into the partial
//                result word and registers everything for the next segment.
//                Holds all state while i_en is low.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_seg
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4,
    parameter int IDX   = 0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_en,
    input  wire logic             i_valid,
    input  wire logic             i_carry,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    input  wire logic [WIDTH-1:0] i_res,
    output logic                  o_valid,
    output logic                  o_carry,
    output logic                  o_ovf,
    output logic [WIDTH-1:0]      o_a,
    output logic [WIDTH-1:0]      o_b,
    output logic [WIDTH-1:0]      o_res
);

    localparam int SW = WIDTH / SEGS;
    localparam int LO = int'(seg_lsb(IDX, SW));
    localparam int HI = LO + SW - 1;

    logic [SW:0]      w_slice;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    // Slice adder; the extra top bit is the carry out of this slice.
    assign w_slice = {1'b0, i_a[HI:LO]} + {1'b0, i_b[HI:LO]} + {{SW{1'b0}}, i_carry};

    // Partial result: lower slices pass through, this slice is filled in.
    always_comb begin
        w_res        = i_res;
        w_res[HI:LO] = w_slice[SW-1:0];
    end

    // Only the segment holding the word MSB can produce signed overflow.
    generate
        if (IDX == SEGS - 1) begin : g_ovf_msb
            logic w_carry_into_msb;
            assign w_carry_into_msb = i_a[HI] ^ i_b[HI] ^ w_slice[SW-1];
            assign w_ovf            = w_carry_into_msb ^ w_slice[SW];
        end else begin : g_ovf_none
            assign w_ovf = 1'b0;
        end
    endgenerate

    // Stage register with hold enable; reset clears valid and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid <= 1'b0;
            o_carry <= 1'b0;
            o_ovf   <= 1'b0;
            o_a     <= '0;
            o_b     <= '0;
            o_res   <= '0;
        end else if (i_en) begin
            o_valid <= i_valid;
            o_carry <= w_slice[SW];
            o_ovf   <= w_ovf;
            o_a     <= i_a;
            o_b     <= i_b;
            o_res   <= w_res;
        end
    end

endmodule : add_seg
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_addsub
//  Description : Pipelined add/subtract unit. The WIDTH-bit carry chain is cut
//                into SEGS slices, one slice per pipeline stage, giving a
//                latency of SEGS cycles and a throughput of one op per cycle.
//                A single global advance signal stalls every stage at once.
//                WIDTH must be divisible by SEGS.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    pipe_addsub_if.slave  bus
);

    // Index k is the input of stage k; index SEGS is the final stage output.
    logic [SEGS:0]    w_valid;
    logic [SEGS:0]    w_carry;
    logic [SEGS:0]    w_ovf;
    logic [WIDTH-1:0] w_a   [SEGS+1];
    logic [WIDTH-1:0] w_b   [SEGS+1];
    logic [WIDTH-1:0] w_res [SEGS+1];
    logic             w_advance;
    logic             w_is_sub;
    logic             w_unused_tail;

    // The pipeline moves whenever the final slot is empty or being drained.
    assign w_advance    = !w_valid[SEGS] || bus.out_ready;
    assign bus.in_ready = w_advance;

    // Subtract enters the chain as a + ~b with carry-in 1.
    assign w_is_sub   = (bus.op == OP_SUB);
    assign w_valid[0] = bus.in_valid;
    assign w_carry[0] = w_is_sub;
    assign w_ovf[0]   = 1'b0;
    assign w_a[0]     = bus.a;
    assign w_b[0]     = w_is_sub ? ~bus.b : bus.b;
    assign w_res[0]   = '0;

    generate
        for (genvar k = 0; k < SEGS; k++) begin : g_seg
            add_seg #(
                .WIDTH (WIDTH),
                .SEGS  (SEGS),
                .IDX   (k)
            ) u_seg (
                .clk     (clk),
                .rst     (rst),
                .i_en    (w_advance),
                .i_valid (w_valid[k]),
                .i_carry (w_carry[k]),
                .i_a     (w_a[k]),
                .i_b     (w_b[k]),
                .i_res   (w_res[k]),
                .o_valid (w_valid[k+1]),
                .o_carry (w_carry[k+1]),
                .o_ovf   (w_ovf[k+1]),
                .o_a     (w_a[k+1]),
                .o_b     (w_b[k+1]),
                .o_res   (w_res[k+1])
            );
        end
    endgenerate

    // Operand copies leaving the last stage and inner-stage overflow flags
    // have no consumer.
    assign w_unused_tail = ^{w_ovf[SEGS-1:0], w_a[SEGS], w_b[SEGS]};

    // Result presentation; everything reads zero while no result is valid.
    assign bus.out_valid = w_valid[SEGS];
    assign bus.sum       = w_valid[SEGS] ? w_res[SEGS] : '0;
    assign bus.cout      = w_valid[SEGS] & w_carry[SEGS];
    assign bus.ovf       = w_valid[SEGS] & w_ovf[SEGS];
    assign bus.zero      = w_valid[SEGS] & (w_res[SEGS] == '0);

endmodule : pipe_addsub
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_addsub
//  Description : Self-checking bench for pipe_addsub (WIDTH=32, SEGS=4):
//                directed vector table, stall and mid-flight reset sequences,
//                and randomized traffic against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_addsub;
    import pipe_addsub_pkg::*;

    localparam int WIDTH = 32;
    localparam int SEGS  = 4;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

    pipe_addsub #(.WIDTH(WIDTH), .SEGS(SEGS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    exp_t exp_next;
    int   n_chk        = 0;
    int   n_fail       = 0;
    int   cyc          = 0;
    int   n_out        = 0;
    bit   chk_lat      = 1'b0;
    bit   expect_stall = 1'b0;
    bit   last_acc     = 1'b0;

    // Reference: plain unsigned/signed arithmetic, no carry-chain modelling.
    function automatic exp_t model(input logic op, input logic [31:0] a, input logic [31:0] b);
        exp_t            e;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned t;
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op) begin
            e.sum  = a - b;
            e.cout = (ua >= ub);
            e.ovf  = (a[31] != b[31]) && (e.sum[31] != a[31]);
        end else begin
            t      = ua + ub;
            e.sum  = t[31:0];
            e.cout = t[32];
            e.ovf  = (a[31] == b[31]) && (e.sum[31] != a[31]);
        end
        e.zero = (e.sum == 32'd0);
        e.acc  = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic v, input logic op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = v;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        exp_next     = model(op, a, b);
    endtask

    // One clock cycle: sample/check outputs, account transfers, advance.
    task automatic tick();
        exp_t f;
        logic in_fire;
        logic out_fire;
        #1;
        in_fire  = bus.in_valid && bus.in_ready && !rst;
        out_fire = bus.out_valid && bus.out_ready;
        last_acc = in_fire;
        if (!rst)
            chk("in_ready_rule", {31'd0, bus.in_ready}, {31'd0, !bus.out_valid || bus.out_ready});
        if (expect_stall)
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_out_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                f = sb[0];
                chk("sum",  bus.sum, f.sum);
                chk("cout", {31'd0, bus.cout}, {31'd0, f.cout});
                chk("ovf",  {31'd0, bus.ovf},  {31'd0, f.ovf});
                chk("zero", {31'd0, bus.zero}, {31'd0, f.zero});
                if (out_fire) begin
                    if (chk_lat)
                        chk("latency", cyc - f.acc, SEGS);
                    void'(sb.pop_front());
                    n_out++;
                end
            end
        end
        if (rst)
            sb.delete();
        if (in_fire) begin
            f     = exp_next;
            f.acc = cyc;
            sb.push_back(f);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input string nm, input int bound);
        for (int w = 0; w < bound && sb.size() > 0; w++)
            tick();
        chk(nm, sb.size(), 32'd0);
    endtask

    initial begin
        vec_t tbl[10];
        int   sent;
        int   n_out0;
        logic v;
        logic [31:0] ra;
        logic [31:0] rb;
        int   pick;

        tbl[0] = '{op:1'b0, a:32'h7FFFFFFF, b:32'h00000001, sum:32'h80000000, cout:1'b0, ovf:1'b1, zero:1'b0};
        tbl[1] = '{op:1'b0, a:32'hFFFFFFFF, b:32'h00000001, sum:32'h00000000, cout:1'b1, ovf:1'b0, zero:1'b1};
        tbl[2] = '{op:1'b1, a:32'h00000003, b:32'h00000005, sum:32'hFFFFFFFE, cout:1'b0, ovf:1'b0, zero:1'b0};
        tbl[3] = '{op:1'b1, a:32'h00000005, b:32'h00000005, sum:32'h00000000, cout:1'b1, ovf:1'b0, zero:1'b1};
        tbl[4] = '{op:1'b1, a:32'h80000000, b:32'h00000001, sum:32'h7FFFFFFF, cout:1'b1, ovf:1'b1, zero:1'b0};
        tbl[5] = '{op:1'b0, a:32'h80000000, b:32'h80000000, sum:32'h00000000, cout:1'b1, ovf:1'b1, zero:1'b1};
        tbl[6] = '{op:1'b0, a:32'h0000FFFF, b:32'h00000001, sum:32'h00010000, cout:1'b0, ovf:1'b0, zero:1'b0};
        tbl[7] = '{op:1'b1, a:32'h00000000, b:32'h00000000, sum:32'h00000000, cout:1'b1, ovf:1'b0, zero:1'b1};
        tbl[8] = '{op:1'b0, a:32'h12345678, b:32'h9ABCDEF0, sum:32'hACF13568, cout:1'b0, ovf:1'b0, zero:1'b0};
        tbl[9] = '{op:1'b1, a:32'h00000000, b:32'h00000001, sum:32'hFFFFFFFF, cout:1'b0, ovf:1'b0, zero:1'b0};

        rst           = 1'b1;
        bus.out_ready = 1'b0;
        drive(1'b1, 1'b0, 32'h1, 32'h2);
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sum",       bus.sum, 32'd0);
        chk("rst_cout",      {31'd0, bus.cout}, 32'd0);
        chk("rst_ovf",       {31'd0, bus.ovf},  32'd0);
        chk("rst_zero",      {31'd0, bus.zero}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        cyc++;

        // Directed vectors, one at a time, with latency check.
        bus.out_ready = 1'b1;
        chk_lat       = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
            exp_next.sum  = tbl[i].sum;
            exp_next.cout = tbl[i].cout;
            exp_next.ovf  = tbl[i].ovf;
            exp_next.zero = tbl[i].zero;
            tick();
            drive(1'b0, 1'b0, 32'h0, 32'h0);
            drain("tbl_drain", 12);
        end

        // Eight back-to-back ops with the consumer stalled for three cycles.
        chk_lat = 1'b0;
        n_out0  = n_out;
        sent    = 0;
        for (int r = 0; r < 40 && (sent < 8 || sb.size() > 0); r++) begin
            bus.out_ready = !(r >= 5 && r <= 7);
            expect_stall  = (r >= 5 && r <= 7);
            if (sent < 8)
                drive(1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            else
                drive(1'b0, 1'b0, 32'h0, 32'h0);
            tick();
            if (last_acc)
                sent++;
        end
        expect_stall  = 1'b0;
        bus.out_ready = 1'b1;
        chk("stall_results", n_out - n_out0, 32'd8);
        chk("stall_drain", sb.size(), 32'd0);

        // Reset with three operand sets in flight; the offered op is dropped.
        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h100 + i, 32'h1);
            tick();
        end
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'hDEAD, 32'hBEEF);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 8; i++)
            tick();
        drive(1'b1, 1'b1, 32'h00000010, 32'h00000004);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        drain("midrst_drain", 12);

        // Randomized traffic with random bubbles and back-pressure.
        chk_lat = 1'b0;
        sent    = 0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            v    = ($urandom_range(0, 3) != 0);
            pick = $urandom_range(0, 7);
            ra   = $urandom;
            rb   = (pick == 0) ? ra : (pick == 1) ? ~ra : (pick == 2) ? 32'h80000000 : $urandom;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            drive(v, 1'($urandom_range(0, 1)), ra, rb);
            tick();
            if (last_acc)
                sent++;
        end
        chk("rand_sent", sent, 32'd10000);
        bus.out_ready = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        drain("rand_drain", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule : tb_pipe_addsub
`default_nettype wire

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter SEGS, default 4, number of carry-chain segments, equal to pipeline depth; WIDTH SHALL be divisible by SEGS.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 out_valid  output  1  result presented.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-012 cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  two's-complement signed overflow.
REQ-014 zero  output  1  1 when sum == 0.

Function
REQ-015 Subtract SHALL be computed as a + ~b + 1, with the carry-in of segment 0 equal to op.
REQ-016 Stage k (0..SEGS-1) SHALL add slice k of both operands plus the registered carry out of stage k-1 and register the slice result, its carry, and the still-unprocessed upper slices.
REQ-017 Completed lower slices SHALL be carried forward through later stages so that a full WIDTH result emerges aligned after stage SEGS-1.
REQ-018 Latency: an operand set accepted in cycle N SHALL appear with out_valid=1 in cycle N+SEGS when there is no stall.
REQ-019 Throughput: one operand set per cycle when out_ready=1 continuously.
REQ-020 Global advance = !out_valid || out_ready; in_ready SHALL equal advance, combinationally.
REQ-021 A transfer on the input occurs when in_valid && in_ready; on the output when out_valid && out_ready.
REQ-022 When advance=0, every stage register (data and valid) SHALL hold; sum/cout/ovf/zero SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 Bubbles (in_valid=0 while advance=1) SHALL propagate as valid=0 stages; they do not block later operands.
REQ-024 ovf SHALL be computed from the final-stage MSB: carry into MSB XOR carry out of MSB.
REQ-025 zero SHALL be derived from the registered final sum, not from the inputs.
REQ-026 Results SHALL leave in acceptance order; none are dropped or duplicated.
REQ-027 With SEGS=1 the block SHALL degenerate to a single-register adder with latency 1.

Reset
REQ-028 While rst=1 at a clock edge, all stage valid bits SHALL clear; out_valid=0 in the following cycle.
REQ-029 Reset values: sum=0, cout=0, ovf=0, zero=0 (flags gated by out_valid = 0).
REQ-030 Reset mid-operation SHALL discard all in-flight operand sets; in_ready SHALL be 1 in the cycle after rst deasserts.
REQ-031 An input offered during a cycle with rst=1 SHALL NOT be accepted.

Structure
REQ-032 Op encoding constants (OP_ADD=0, OP_SUB=1) SHALL live in the shared package pipe_addsub_pkg used by the ALU.
REQ-033 One stage SHALL be a sub-module add_seg (slice adder plus pipeline register with hold enable), instantiated SEGS times via generate.
REQ-034 No combinational path from a/b to sum; only out_ready -> in_ready is combinational.

Verification (WIDTH=32, SEGS=4)
REQ-035 add 0x7FFFFFFF + 0x00000001 -> after 4 cycles sum=0x80000000, cout=0, ovf=1, zero=0.
REQ-036 add 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, cout=1, ovf=0, zero=1.
REQ-037 sub 3 - 5 -> sum=0xFFFFFFFE, cout=0, ovf=0; sub 5 - 5 -> sum=0, cout=1, zero=1.
REQ-038 8 back-to-back ops with out_ready=0 for cycles 5-7 -> in_ready=0 during stall, outputs held, all 8 results in order, none lost.
REQ-039 rst=1 for one cycle with 3 ops in flight -> out_valid=0 next cycle, no stale result ever appears, next op emerges 4 cycles after acceptance.
REQ-040 Random 10k ops with random in_valid/out_ready -> every result matches a reference model of {cout,sum}=a+(op?~b+1:b) and the ovf/zero rules.
